branch_history_table: RTL and testbench
=======================================

# branch_history_table

Pattern-history table and branch resolution unit: the update side of the pipeline's 2-bit dynamic branch prediction. The fetch stage reads a 2-bit saturating counter for the current PC. The table hands it to the predictor, which chooses between the sequential PC and the branch target. When a branch resolves in EX, this block trains the counter, detects a misprediction, and drives the redirect PC. It also keeps branch and miss performance counters.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of the entry count; 64 entries by default.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- rd_pc  in  `ADDR_SIZE  fetch-stage PC.
- rd_state  out  2  counter for rd_pc; feeds the predictor's state input.
- upd_valid  in  1  a resolved conditional branch is in EX this cycle.
- upd_pc  in  `ADDR_SIZE  PC of the resolving branch.
- upd_taken  in  1  actual branch outcome.
- upd_pred_pc  in  `ADDR_SIZE  next PC that fetch predicted for this branch, carried down the pipe.
- upd_actual_pc  in  `ADDR_SIZE  resolved next PC: the target if taken, pc+4 otherwise.
- mispredict  out  1  flush request for IF/ID.
- redirect_pc  out  `ADDR_SIZE  PC that fetch must load when mispredict=1.
- init_busy  out  1  table clear in progress.
- branch_cnt  out  CNT_W  number of resolved branches.
- miss_cnt  out  CNT_W  number of mispredicted branches.

## Operation
- Storage: 2^INDEX_BITS entries of 2 bits each. The index is pc[INDEX_BITS+1:2] for both the read and the update port. There are no tags, so aliasing is accepted.
- State machine, two states:
  - INIT: a clear pointer walks from 0 to 2^INDEX_BITS-1 and writes 2'b00 to one entry per cycle. init_busy=1. rd_state is forced to 2'b00. Table updates are dropped.
  - RUN: normal operation. init_busy=0.
- INIT transitions to RUN on the cycle the pointer writes the last entry. There is no transition out of RUN except through reset.
- reset=1 in any state forces INIT with the pointer at 0. A reset in the middle of the clear restarts the clear from index 0.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Counter training in RUN when upd_valid=1:
  - upd_taken=1: next = (s==3) ? 3 : s+1.
  - upd_taken=0: next = (s==0) ? 0 : s-1.
  - No wrap in either direction.
- Misprediction check:
  - mispredict = upd_valid & (upd_pred_pc != upd_actual_pc). This is combinational and is valid in INIT too.
  - redirect_pc = upd_actual_pc whenever upd_valid=1, and 0 otherwise.
- Performance counters:
  - branch_cnt increments when upd_valid=1.
  - miss_cnt increments when mispredict=1.
  - Both count in INIT and RUN, and wrap modulo 2^CNT_W.
- Read port: rd_state is a combinational read of the entry indexed by rd_pc (subject to the INIT override).

## Timing
- Reset values:
  - all table entries are 2'b00 once the clear completes;
  - init_busy=1, rd_state=2'b00;
  - branch_cnt=0, miss_cnt=0;
  - mispredict and redirect_pc follow their inputs, so both are 0 when upd_valid=0.
- Clear latency: init_busy stays 1 while reset is high and for exactly 2^INDEX_BITS cycles after reset deasserts. It is 64 cycles by default.
- Counter write latency: a table write takes effect at the rising edge that ends the upd_valid cycle, so it is visible to reads from the next cycle on.
- Same-index read and update in one cycle: rd_state returns the pre-update value (see Configuration).
- mispredict and redirect_pc have zero latency, in the same cycle as upd_valid.
- Performance counters update at the same edge as the table.

## Configuration
- BHT_BYPASS_EN defined: when upd_valid=1 in RUN and rd_pc and upd_pc index the same entry, rd_state returns the newly trained value in that same cycle.
- BHT_BYPASS_EN undefined: rd_state always returns the stored (old) value. The write lands at the clock edge.

## Test plan
- Reset clear:
  - Stimulus: assert reset for 3 cycles, release, then hold upd_valid=1 with upd_taken=1 for 64 cycles at pc 0x10.
  - Required: init_busy=1 for exactly 64 cycles after release. Entry 4 remains 00 (updates dropped), and branch_cnt=64.
- Saturation:
  - Stimulus: in RUN, apply 5 taken updates to pc 0x20, then 5 not-taken updates.
  - Required: rd_state at pc 0x20 steps through 01,10,11,11,11, then 10,01,00,00,00.
- Misprediction:
  - Stimulus: upd_valid=1 with upd_pred_pc=0x104 and upd_actual_pc=0x200.
  - Required: in the same cycle mispredict=1 and redirect_pc=0x200, then miss_cnt increments by 1.
  - Stimulus: equal PCs.
  - Required: mispredict=0.
- Aliasing:
  - Stimulus: with INDEX_BITS=6, train pc 0x0 taken twice.
  - Required: a read at pc 0x100 returns 10.
- Read/update collision:
  - Stimulus: rd_pc=upd_pc=0x40, entry at 01, upd_taken=1.
  - Required: rd_state=01 without BHT_BYPASS_EN, and 10 with it. The next cycle reads 10 in both builds.
- Reset mid-clear:
  - Stimulus: pulse reset at clear cycle 30.
  - Required: init_busy stays 1 for 64 further cycles after release, and miss_cnt and branch_cnt read 0.

Source files
------------

// File: rtl/branch_history_table.sv
// 2-bit pattern-history table with branch resolution, redirect and perf counters.
// Optional same-cycle read bypass of a colliding update: define BHT_BYPASS_EN.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module branch_history_table #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [`ADDR_SIZE-1:0] rd_pc,
   output logic [1:0]            rd_state,
   input  logic                  upd_valid,
   input  logic [`ADDR_SIZE-1:0] upd_pc,
   input  logic                  upd_taken,
   input  logic [`ADDR_SIZE-1:0] upd_pred_pc,
   input  logic [`ADDR_SIZE-1:0] upd_actual_pc,
   output logic                  mispredict,
   output logic [`ADDR_SIZE-1:0] redirect_pc,
   output logic                  init_busy,
   output logic [CNT_W-1:0]      branch_cnt,
   output logic [CNT_W-1:0]      miss_cnt
);

   localparam int unsigned Entries = 1 << INDEX_BITS;

   localparam logic [0:0] StInit = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]      branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;
   logic [1:0]            table_q [Entries];

   logic [INDEX_BITS-1:0] rd_idx, upd_idx;
   logic [1:0]            upd_old, upd_new;
   logic                  clear_we, upd_we;

   assign rd_idx  = rd_pc[INDEX_BITS+1:2];
   assign upd_idx = upd_pc[INDEX_BITS+1:2];

   // PC bits outside the index field do not participate (untagged table).
   logic unused_pc_bits;
   assign unused_pc_bits = ^{rd_pc[`ADDR_SIZE-1:INDEX_BITS+2], rd_pc[1:0],
                             upd_pc[`ADDR_SIZE-1:INDEX_BITS+2], upd_pc[1:0]};

   assign upd_old  = table_q[upd_idx];
   assign clear_we = (state_q == StInit);
   assign upd_we   = (state_q == StRun) && upd_valid && !reset;

   always_comb begin
      upd_new = upd_old;
      if (upd_taken) begin
         if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
      end else begin
         if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
      end
   end

   assign mispredict  = upd_valid && (upd_pred_pc != upd_actual_pc);
   assign redirect_pc = upd_valid ? upd_actual_pc : '0;
   assign init_busy   = (state_q == StInit);
   assign branch_cnt  = branch_cnt_q;
   assign miss_cnt    = miss_cnt_q;

   always_comb begin
      rd_state = table_q[rd_idx];
      if (state_q == StInit) begin
         rd_state = 2'b00;
`ifdef BHT_BYPASS_EN
      end else if (upd_we && (rd_idx == upd_idx)) begin
         rd_state = upd_new;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (state_q == StInit) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == {INDEX_BITS{1'b1}}) state_d = StRun;
      end
      if (upd_valid) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict) miss_cnt_d = miss_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StInit;
         ptr_q        <= '0;
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Storage has no reset of its own; the clear walk initialises it.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         table_q[ptr_q] <= 2'b00;
      end else if (upd_we) begin
         table_q[upd_idx] <= upd_new;
      end
   end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed self-checking bench for branch_history_table (default parameters).
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module tb_branch_history_table;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [`ADDR_SIZE-1:0] rd_pc;
   logic [1:0]            rd_state;
   logic                  upd_valid;
   logic [`ADDR_SIZE-1:0] upd_pc;
   logic                  upd_taken;
   logic [`ADDR_SIZE-1:0] upd_pred_pc;
   logic [`ADDR_SIZE-1:0] upd_actual_pc;
   logic                  mispredict;
   logic [`ADDR_SIZE-1:0] redirect_pc;
   logic                  init_busy;
   logic [31:0]           branch_cnt;
   logic [31:0]           miss_cnt;

   int checks = 0;
   int errors = 0;

   branch_history_table #(
      .INDEX_BITS(6),
      .CNT_W     (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_pc        (rd_pc),
      .rd_state     (rd_state),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_pred_pc  (upd_pred_pc),
      .upd_actual_pc(upd_actual_pc),
      .mispredict   (mispredict),
      .redirect_pc  (redirect_pc),
      .init_busy    (init_busy),
      .branch_cnt   (branch_cnt),
      .miss_cnt     (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One resolved branch with matching prediction, then bus idle.
   task automatic train(input logic [31:0] pc, input logic taken);
      upd_valid     = 1'b1;
      upd_pc        = pc;
      upd_taken     = taken;
      upd_pred_pc   = pc + 32'd4;
      upd_actual_pc = pc + 32'd4;
      step();
      upd_valid = 1'b0;
   endtask

   task automatic wait_clear(output int cycles);
      cycles = 0;
      while (init_busy && cycles < 200) begin
         step();
         cycles++;
      end
   endtask

   logic [1:0] sat_exp [10] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
   int cyc;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; rd_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_pred_pc = '0; upd_actual_pc = '0;
      step(); step(); step();
      check("rst_init_busy", init_busy, 1);
      check("rst_rd_state", rd_state, 0);
      check("rst_branch_cnt", branch_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      check("rst_mispredict", mispredict, 0);
      check("rst_redirect", redirect_pc, 0);

      // Release reset and stream taken updates at 0x10 throughout the clear.
      reset = 1'b0; upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
      upd_pred_pc = 32'h14; upd_actual_pc = 32'h14;
      wait_clear(cyc);
      upd_valid = 1'b0;
      check("clear_cycles", cyc, 64);
      check("clear_branch_cnt", branch_cnt, 64);
      check("clear_miss_cnt", miss_cnt, 0);
      rd_pc = 32'h10; #1;
      check("clear_dropped_entry4", rd_state, 0);

      // Saturation at 0x20.
      rd_pc = 32'h20;
      for (int i = 0; i < 10; i++) begin
         train(32'h20, i < 5);
         check($sformatf("sat_%0d", i), rd_state, sat_exp[i]);
      end
      check("sat_branch_cnt", branch_cnt, 74);

      // Misprediction.
      upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1;
      upd_pred_pc = 32'h104; upd_actual_pc = 32'h200; #1;
      check("miss_mispredict", mispredict, 1);
      check("miss_redirect", redirect_pc, 32'h200);
      step();
      check("miss_cnt_inc", miss_cnt, 1);
      check("miss_branch_cnt", branch_cnt, 75);
      upd_pred_pc = 32'h104; upd_actual_pc = 32'h104; #1;
      check("hit_mispredict", mispredict, 0);
      check("hit_redirect", redirect_pc, 32'h104);
      step();
      check("hit_miss_cnt", miss_cnt, 1);
      upd_valid = 1'b0; upd_pred_pc = 32'h8; upd_actual_pc = 32'h300; #1;
      check("idle_mispredict", mispredict, 0);
      check("idle_redirect", redirect_pc, 0);
      step();
      check("idle_miss_cnt", miss_cnt, 1);

      // Aliasing: 0x0 and 0x100 share entry 0.
      train(32'h0, 1'b1);
      train(32'h0, 1'b1);
      rd_pc = 32'h100; #1;
      check("alias_0x100", rd_state, 2);
      rd_pc = 32'h4; #1;
      check("alias_neighbour", rd_state, 0);

      // Read/update collision at 0x40.
      rd_pc = 32'h0;
      train(32'h40, 1'b1);
      rd_pc = 32'h40;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
      upd_pred_pc = 32'h44; upd_actual_pc = 32'h44; #1;
`ifdef BHT_BYPASS_EN
      check("collide_same_cycle", rd_state, 2);
`else
      check("collide_same_cycle", rd_state, 1);
`endif
      step();
      upd_valid = 1'b0; #1;
      check("collide_next_cycle", rd_state, 2);

      // Reset in the middle of a clear.
      reset = 1'b1; step();
      reset = 1'b0;
      for (int i = 0; i < 30; i++) step();
      check("midclear_busy", init_busy, 1);
      reset = 1'b1; step();
      check("midclear_branch_cnt", branch_cnt, 0);
      check("midclear_miss_cnt", miss_cnt, 0);
      reset = 1'b0;
      wait_clear(cyc);
      check("midclear_cycles", cyc, 64);
      check("midclear_branch_cnt_end", branch_cnt, 0);
      check("midclear_miss_cnt_end", miss_cnt, 0);
      rd_pc = 32'h40; #1;
      check("midclear_entry16_cleared", rd_state, 0);
      rd_pc = 32'h100; #1;
      check("midclear_entry0_cleared", rd_state, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
